// File: rtl/bram_rd_pkg.sv
// Shared types and helpers for the BRAM read-port arbiter.
package bram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RETIRE = 2'd2
  } state_t;

  localparam int BRAM_ADDR_W = 13;
  localparam int BRAM_DATA_W = 32;

  // Round-robin winner for up to 8 lanes: requests above the last owner take
  // priority, otherwise fall back to the lowest requesting lane.
  function automatic logic [2:0] rr_next(input logic [7:0] req,
                                         input logic [7:0] lanes,
                                         input logic [2:0] last);
    logic [7:0] hi;
    logic [7:0] masked;
    logic [7:0] live;
    logic [2:0] res;
    res  = 3'd0;
    live = req & lanes;
    for (int i = 0; i < 8; i++) begin
      hi[i] = (3'(i) > last);
    end
    masked = live & hi;
    if (|masked) begin
      for (int i = 7; i >= 0; i--) begin
        if (masked[i]) res = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (live[i]) res = 3'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_rd_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot and index of the next owner.
module rr_pick
  import bram_rd_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [7:0] LANES = 8'((1 << N_REQ) - 1);

  logic [7:0] req8;
  logic [2:0] win;

  always_comb begin
    req8             = '0;
    req8[N_REQ-1:0]  = i_req;
    win              = rr_next(req8, LANES, 3'(i_last));
    o_idx            = IDX_W'(win);
    o_onehot         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      o_onehot[k] = (|i_req) && (win == 3'(k));
    end
  end

endmodule

// File: rtl/bram_rd_arbiter.sv
// Round-robin arbiter sharing one trig/done BRAM read port among N_REQ requesters.
// Optional BUSY watchdog enabled by defining BRAM_RD_TIMEOUT_EN.
module bram_rd_arbiter
  import bram_rd_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = BRAM_ADDR_W,
  parameter int DATA_W  = BRAM_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [N_REQ-1:0]        i_req_trig,
  input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
  output logic [N_REQ-1:0]        o_req_done,
  output logic [DATA_W-1:0]       o_req_data,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_bram_trig,
  output logic [ADDR_W-1:0]       o_bram_addr,
  input  logic [DATA_W-1:0]       i_bram_data,
  input  logic                    i_bram_done,
  output logic                    o_timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                trig_q, trig_d;

  logic [N_REQ-1:0]    pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic [ADDR_W-1:0]   addr_sel;
  logic                owner_trig;

`ifdef BRAM_RD_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                terr_q, terr_d;
`else
  // TIMEOUT only matters in the watchdog build.
  logic                unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req    (i_req_trig),
    .i_last   (last_q),
    .o_onehot (pick_oh),
    .o_idx    (pick_idx)
  );

  always_comb begin
    addr_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_oh[k]) addr_sel = i_req_addr[k*ADDR_W +: ADDR_W];
    end
  end

  assign owner_trig = |(i_req_trig & grant_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    done_d  = done_q;
    data_d  = data_q;
    addr_d  = addr_q;
    trig_d  = trig_q;
`ifdef BRAM_RD_TIMEOUT_EN
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|i_req_trig) begin
          grant_d = pick_oh;
          addr_d  = addr_sel;
          trig_d  = 1'b1;
          last_d  = pick_idx;
          state_d = BUSY;
`ifdef BRAM_RD_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
`ifdef BRAM_RD_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // A dropped owner trig beats a same-cycle done: no data, no done.
        if (!owner_trig) begin
          trig_d  = 1'b0;
          state_d = RETIRE;
        end else if (i_bram_done) begin
          data_d  = i_bram_data;
          done_d  = grant_q;
          trig_d  = 1'b0;
          state_d = RETIRE;
        end
`ifdef BRAM_RD_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          trig_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = RETIRE;
        end
`endif
      end
      RETIRE: begin
        // One trig-low cycle lets the BRAM-side latency counter re-arm.
        done_d  = '0;
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        done_d  = '0;
        trig_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      trig_q  <= 1'b0;
`ifdef BRAM_RD_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      trig_q  <= trig_d;
`ifdef BRAM_RD_TIMEOUT_EN
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  assign o_req_done  = done_q & i_req_trig;
  assign o_req_data  = data_q;
  assign o_grant     = grant_q;
  assign o_bram_trig = trig_q;
  assign o_bram_addr = addr_q;
`ifdef BRAM_RD_TIMEOUT_EN
  assign o_timeout_err = terr_q;
`else
  assign o_timeout_err = 1'b0;
`endif

endmodule
